// File: rtl/alu_seq_mult_if.sv
// Operand/result bundle for the iterative multiplier.
// The requester drives start/a/b; the multiplier returns status and product.
interface alu_seq_mult_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product_lo;
  logic [WIDTH-1:0] product_hi;

  modport master (
    output start, a, b,
    input  busy, done, product_lo, product_hi
  );

  modport slave (
    input  start, a, b,
    output busy, done, product_lo, product_hi
  );
endinterface

// File: rtl/alu_seq_mult.sv
// Radix-2 shift-add unsigned multiplier, fixed WIDTH-cycle latency.
// Product halves feed the ALU result mux as MUL (lo) and UMULH (hi).
module alu_seq_mult #(
  parameter int WIDTH = 64
) (
  input logic           clk,
  input logic           reset,
  alu_seq_mult_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    sum;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] product_lo;
  logic [WIDTH-1:0] product_hi;
  logic             accept;
  logic             last;

  assign accept = (state != RUN) && bus.start;
  assign last   = (state == RUN) && (count == CW'(WIDTH - 1));
  assign addend = mplier[0] ? mcand : '0;
  // Carry out of this adder is always zero for unsigned operands.
  assign sum    = acc + addend;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = bus.start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.busy       = (state == RUN);
    bus.done       = (state == DONE);
    bus.product_lo = product_lo;
    bus.product_hi = product_hi;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      count      <= '0;
      product_lo <= '0;
      product_hi <= '0;
    end else if (accept) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, bus.a};
      mplier <= bus.b;
      count  <= '0;
    end else if (state == RUN) begin
      acc    <= sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
      if (last) {product_hi, product_lo} <= sum;
    end
  end
endmodule

// File: tb/tb_alu_seq_mult.sv
// Randomised self-checking bench for alu_seq_mult.
// Expected products come from plain 128-bit multiplication.
module tb_alu_seq_mult;
  localparam int W = 64;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  alu_seq_mult_if #(.WIDTH(W)) bus ();

  alu_seq_mult #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_mul(
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    logic [2*W-1:0] xx;
    logic [2*W-1:0] yy;
    xx = {{W{1'b0}}, x};
    yy = {{W{1'b0}}, y};
    return xx * yy;
  endfunction

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [W-1:0] x, input logic [W-1:0] y);
    bus.a     = x;
    bus.b     = y;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Waits for done while scrambling a/b; lat counts edges after acceptance.
  task automatic wait_done(output int lat, output int busy_n, output bit to);
    lat    = 0;
    busy_n = bus.busy ? 1 : 0;
    to     = 1'b1;
    for (int i = 0; i < 4 * W; i++) begin
      bus.a = rnd64();
      bus.b = rnd64();
      tick();
      lat++;
      if (bus.done) begin
        to = 1'b0;
        break;
      end
      if (bus.busy) busy_n++;
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b expected 0", bus.busy);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b expected 0", bus.done);
    end
    checks++;
    if ({bus.product_hi, bus.product_lo} !== '0) begin
      errors++;
      $display("FAIL reset_product: got %h_%h expected 0",
               bus.product_hi, bus.product_lo);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    int bn;
    bit to;
    do_start(64'd3, 64'd5);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_start: got %b expected 1", bus.busy);
    end
    wait_done(lat, bn, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL basic_timeout: got no done expected done");
    end
    checks++;
    if (lat !== W) begin
      errors++;
      $display("FAIL basic_latency: got %0d expected %0d", lat, W);
    end
    checks++;
    if (bn !== W) begin
      errors++;
      $display("FAIL basic_busy_cycles: got %0d expected %0d", bn, W);
    end
    checks++;
    if (bus.product_lo !== 64'd15 || bus.product_hi !== 64'd0) begin
      errors++;
      $display("FAIL basic_product: got %h_%h expected 0_f",
               bus.product_hi, bus.product_lo);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: got done=%b busy=%b expected 0 0",
               bus.done, bus.busy);
    end
  endtask

  task automatic test_max();
    int lat;
    int bn;
    bit to;
    do_start('1, '1);
    wait_done(lat, bn, to);
    checks++;
    if (to || bus.product_hi !== 64'hFFFF_FFFF_FFFF_FFFE ||
        bus.product_lo !== 64'h1) begin
      errors++;
      $display("FAIL max_product: got %h_%h expected fffffffffffffffe_1",
               bus.product_hi, bus.product_lo);
    end
  endtask

  task automatic test_hold();
    int lat;
    int bn;
    bit to;
    bit held;
    logic [2*W-1:0] prev;
    do_start(64'h8000_0000_0000_0000, 64'd2);
    wait_done(lat, bn, to);
    checks++;
    if (to || bus.product_hi !== 64'd1 || bus.product_lo !== 64'd0) begin
      errors++;
      $display("FAIL hold_first: got %h_%h expected 1_0",
               bus.product_hi, bus.product_lo);
    end
    prev = {bus.product_hi, bus.product_lo};
    repeat (3) tick();
    held = ({bus.product_hi, bus.product_lo} === prev);
    do_start(64'd0, 64'd12345);
    to = 1'b1;
    for (int i = 0; i < 4 * W; i++) begin
      if (!bus.busy) break;
      if ({bus.product_hi, bus.product_lo} !== prev) held = 1'b0;
      tick();
      if (bus.done) begin
        to = 1'b0;
        break;
      end
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL hold_during_run: got changed expected %h", prev);
    end
    checks++;
    if (to || {bus.product_hi, bus.product_lo} !== '0) begin
      errors++;
      $display("FAIL hold_zero: got %h_%h expected 0_0",
               bus.product_hi, bus.product_lo);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int bn;
    bit to;
    do_start(64'd7, 64'd9);
    repeat (9) tick();
    bus.a     = 64'd2;
    bus.b     = 64'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL ignore_busy: got %b expected 1", bus.busy);
    end
    wait_done(lat, bn, to);
    checks++;
    if (to || bus.product_lo !== 64'd63 || bus.product_hi !== 64'd0) begin
      errors++;
      $display("FAIL ignore_product: got %h_%h expected 0_3f",
               bus.product_hi, bus.product_lo);
    end
    do_start(64'd4, 64'd4);
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b done=%b expected 1 0",
               bus.busy, bus.done);
    end
    checks++;
    if (bus.product_lo !== 64'd63) begin
      errors++;
      $display("FAIL b2b_hold: got %h expected 3f", bus.product_lo);
    end
    wait_done(lat, bn, to);
    checks++;
    if (to || lat !== W || bus.product_lo !== 64'd16 ||
        bus.product_hi !== 64'd0) begin
      errors++;
      $display("FAIL b2b_product: got %h_%h lat=%0d expected 0_10 lat=%0d",
               bus.product_hi, bus.product_lo, lat, W);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int lat;
    int bn;
    bit to;
    bit saw_done;
    do_start(64'd6, 64'd7);
    repeat (19) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        {bus.product_hi, bus.product_lo} !== '0) begin
      errors++;
      $display("FAIL abort_state: got busy=%b done=%b prod=%h expected 0 0 0",
               bus.busy, bus.done, bus.product_lo);
    end
    saw_done = 1'b0;
    for (int i = 0; i < W + 8; i++) begin
      tick();
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL abort_no_done: got activity expected none");
    end
    do_start(64'd6, 64'd7);
    wait_done(lat, bn, to);
    checks++;
    if (to || bus.product_lo !== 64'd42 || bus.product_hi !== 64'd0) begin
      errors++;
      $display("FAIL abort_rerun: got %h_%h expected 0_2a",
               bus.product_hi, bus.product_lo);
    end
    tick();
  endtask

  task automatic test_reset_start();
    reset     = 1'b1;
    bus.a     = 64'd9;
    bus.b     = 64'd9;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    reset     = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        {bus.product_hi, bus.product_lo} !== '0) begin
      errors++;
      $display("FAIL rst_start: got busy=%b done=%b lo=%h expected 0 0 0",
               bus.busy, bus.done, bus.product_lo);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_start_idle: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_random();
    int lat;
    int bn;
    bit to;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [2*W-1:0] exp;
    for (int n = 0; n < 10; n++) begin
      x = rnd64();
      y = rnd64();
      if (n == 0) y = 64'd1;
      if (n == 1) x = {32'd0, $urandom};
      exp = ref_mul(x, y);
      do_start(x, y);
      wait_done(lat, bn, to);
      checks++;
      if (to || lat !== W || {bus.product_hi, bus.product_lo} !== exp) begin
        errors++;
        $display("FAIL rand_%0d: got %h lat=%0d expected %h lat=%0d",
                 n, {bus.product_hi, bus.product_lo}, lat, exp, W);
      end
      if (n[0]) tick();
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    test_reset();
    test_basic();
    test_max();
    test_hold();
    test_back_to_back();
    test_reset_abort();
    test_reset_start();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
